// File: rtl/character_stats_if.sv
// Controller-to-stat-block bundle: battle strobes in, combatant stats out.
interface character_stats_if #(
    parameter int HP_W   = 9,
    parameter int SP_W   = 5,
    parameter int DMG_W  = 6,
    parameter int COST_W = 3
);
    logic                     en;
    logic signed [DMG_W-1:0]  hit;
    logic signed [COST_W-1:0] cost;
    logic                     guard;
    logic                     turn_end;
    logic                     poison_in;
    logic                     revive;
    logic [3:0]               speed;
    logic [4:0]               dodge;
    logic [HP_W-1:0]          health;
    logic [SP_W-1:0]          special;
    logic                     poisoned;
    logic                     ko;
    logic                     reject;

    modport master (
        output en, hit, cost, guard, turn_end, poison_in, revive,
        input  speed, dodge, health, special, poisoned, ko, reject
    );

    modport slave (
        input  en, hit, cost, guard, turn_end, poison_in, revive,
        output speed, dodge, health, special, poisoned, ko, reject
    );
endinterface

// File: rtl/character_stats.sv
// Saturating health/special registers for one combatant with guard, poison,
// special regen, spend rejection and an ALIVE/POISONED/KO state machine.
module character_stats #(
    parameter int HP_W         = 9,
    parameter int MAX_HP       = 175,
    parameter int SP_W         = 5,
    parameter int MAX_SP       = 10,
    parameter int DMG_W        = 6,
    parameter int COST_W       = 3,
    parameter int SPEED        = 4,
    parameter int DODGE        = 13,
    parameter int POISON_TURNS = 3,
    parameter int POISON_DMG   = 5,
    parameter int SP_REGEN     = 1
) (
    input logic               clk,
    input logic               rst,
    character_stats_if.slave  bus
);
    localparam int CW   = HP_W + 2;
    localparam int SW   = SP_W + 2;
    localparam int PC_W = (POISON_TURNS < 1) ? 1 : $clog2(POISON_TURNS + 1);
    localparam logic signed [CW-1:0] MAX_HP_S = CW'(MAX_HP);
    localparam logic signed [SW-1:0] MAX_SP_S = SW'(MAX_SP);

    typedef enum logic [1:0] {ALIVE, POISONED, KO} state_t;

    state_t           state_q;
    logic [HP_W-1:0]  health_q;
    logic [SP_W-1:0]  special_q;
    logic [PC_W-1:0]  poison_cnt;
    logic             reject_q;

    logic [DMG_W-1:0]         hmag;
    logic [DMG_W-1:0]         damage;
    logic [COST_W-1:0]        cmag;
    logic                     hit_pos;
    logic                     cost_pos;
    logic                     spend_ok;
    logic                     poison_tick;
    logic signed [CW-1:0]     delta;
    logic signed [CW-1:0]     health_sum;
    logic [HP_W-1:0]          health_next;
    logic signed [SW-1:0]     sp_delta;
    logic signed [SW-1:0]     sp_sum;
    logic [SP_W-1:0]          special_next;
    logic [PC_W-1:0]          cnt_next;

    // All same-cycle contributions are netted before a single clamp, so a heal
    // and a poison tick together never lose health to an intermediate ceiling.
    always_comb begin
        hmag        = bus.hit[DMG_W-1] ? DMG_W'(-bus.hit) : DMG_W'(bus.hit);
        cmag        = bus.cost[COST_W-1] ? COST_W'(-bus.cost) : COST_W'(bus.cost);
        hit_pos     = !bus.hit[DMG_W-1] && (bus.hit != '0);
        cost_pos    = !bus.cost[COST_W-1] && (bus.cost != '0);
        damage      = bus.guard ? (hmag >> 1) : hmag;
        spend_ok    = int'(cmag) <= int'(special_q);
        poison_tick = bus.turn_end && (poison_cnt != '0);

        delta = '0;
        if (bus.en) begin
            if (hit_pos)
                delta = delta - CW'(damage);
            else if (bus.hit[DMG_W-1])
                delta = delta + CW'(hmag);
        end
        if (poison_tick)
            delta = delta - CW'(POISON_DMG);
        health_sum = $signed({2'b00, health_q}) + delta;
        if (health_sum[CW-1])
            health_next = '0;
        else if (health_sum > MAX_HP_S)
            health_next = HP_W'(MAX_HP);
        else
            health_next = health_sum[HP_W-1:0];

        sp_delta = '0;
        if (bus.en) begin
            if (cost_pos && spend_ok)
                sp_delta = sp_delta - SW'(cmag);
            else if (bus.cost[COST_W-1])
                sp_delta = sp_delta + SW'(cmag);
        end
        if (bus.turn_end)
            sp_delta = sp_delta + SW'(SP_REGEN);
        sp_sum = $signed({2'b00, special_q}) + sp_delta;
        if (sp_sum[SW-1])
            special_next = '0;
        else if (sp_sum > MAX_SP_S)
            special_next = SP_W'(MAX_SP);
        else
            special_next = sp_sum[SP_W-1:0];

        // Tick uses the old count above; a same-cycle poison_in then reloads it.
        if (bus.poison_in)
            cnt_next = PC_W'(POISON_TURNS);
        else if (poison_tick)
            cnt_next = poison_cnt - 1'b1;
        else
            cnt_next = poison_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ALIVE;
            health_q   <= HP_W'(MAX_HP);
            special_q  <= SP_W'(MAX_SP);
            poison_cnt <= '0;
            reject_q   <= 1'b0;
        end else if (state_q == KO) begin
            reject_q <= 1'b0;
            if (bus.revive) begin
                state_q   <= ALIVE;
                health_q  <= HP_W'(MAX_HP >> 1);
                special_q <= '0;
            end
        end else begin
            health_q  <= health_next;
            special_q <= special_next;
            reject_q  <= bus.en && cost_pos && !spend_ok;
            if (health_next == '0) begin
                state_q    <= KO;
                poison_cnt <= '0;
            end else begin
                poison_cnt <= cnt_next;
                state_q    <= (cnt_next != '0) ? POISONED : ALIVE;
            end
        end
    end

    assign bus.speed    = 4'(SPEED);
    assign bus.dodge    = 5'(DODGE);
    assign bus.health   = health_q;
    assign bus.special  = special_q;
    assign bus.poisoned = (poison_cnt != '0);
    assign bus.ko       = (state_q == KO);
    assign bus.reject   = reject_q;
endmodule

// File: tb/tb_character_stats.sv
// Directed bench for character_stats: hand-computed health/special/poison/KO
// expectations checked one cycle after each stimulus.
module tb_character_stats;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    character_stats_if #(.HP_W(9), .SP_W(5), .DMG_W(6), .COST_W(3)) bus ();

    character_stats dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change #1 after an edge; outputs are sampled #1 after the next edge.
    task automatic applyStimulus(input logic e, input int h, input int c, input logic g,
                                 input logic te, input logic pi, input logic rv);
        bus.en        = e;
        bus.hit       = 6'(h);
        bus.cost      = 3'(c);
        bus.guard     = g;
        bus.turn_end  = te;
        bus.poison_in = pi;
        bus.revive    = rv;
        @(posedge clk);
        #1;
        bus.en        = 1'b0;
        bus.hit       = '0;
        bus.cost      = '0;
        bus.guard     = 1'b0;
        bus.turn_end  = 1'b0;
        bus.poison_in = 1'b0;
        bus.revive    = 1'b0;
    endtask

    task automatic hitOnce(input int h);
        applyStimulus(1'b1, h, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick(input logic pi);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, pi, 1'b0);
    endtask

    // Reset pulse taken mid-cycle; values must appear before any clock edge.
    task automatic pulseReset(input string tag);
        rst = 1'b1;
        #2;
        checkOutput({tag, "_health"}, int'(bus.health), 175);
        checkOutput({tag, "_special"}, int'(bus.special), 10);
        checkOutput({tag, "_ko"}, int'(bus.ko), 0);
        checkOutput({tag, "_poisoned"}, int'(bus.poisoned), 0);
        checkOutput({tag, "_reject"}, int'(bus.reject), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.en        = 1'b0;
        bus.hit       = '0;
        bus.cost      = '0;
        bus.guard     = 1'b0;
        bus.turn_end  = 1'b0;
        bus.poison_in = 1'b0;
        bus.revive    = 1'b0;
        #2;
        pulseReset("rst0");
        checkOutput("speed", int'(bus.speed), 4);
        checkOutput("dodge", int'(bus.dodge), 13);

        // Hit arithmetic
        hitOnce(20);
        checkOutput("hit20", int'(bus.health), 155);
        hitOnce(-32);
        checkOutput("heal_neg32_sat", int'(bus.health), 175);
        applyStimulus(1'b1, 21, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("guard21", int'(bus.health), 165);
        applyStimulus(1'b1, -6, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("guard_heal", int'(bus.health), 171);
        pulseReset("rst_mid");

        for (int i = 0; i < 5; i++) hitOnce(31);
        checkOutput("hit31x5", int'(bus.health), 20);
        checkOutput("hit31x5_ko", int'(bus.ko), 0);
        hitOnce(31);
        checkOutput("hit31x6", int'(bus.health), 0);
        checkOutput("hit31x6_ko", int'(bus.ko), 1);
        pulseReset("rst_cost");

        // Cost / reject / regen
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cost3x3", int'(bus.special), 1);
        checkOutput("cost3x3_rej", int'(bus.reject), 0);
        applyStimulus(1'b1, 4, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reject_pulse", int'(bus.reject), 1);
        checkOutput("reject_sp", int'(bus.special), 1);
        checkOutput("reject_hit", int'(bus.health), 171);
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reject_drop", int'(bus.reject), 0);
        checkOutput("cost0", int'(bus.special), 1);
        applyStimulus(1'b1, 0, -2, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restore2", int'(bus.special), 3);
        tick(1'b0);
        checkOutput("regen", int'(bus.special), 4);
        checkOutput("regen_health", int'(bus.health), 171);
        applyStimulus(1'b1, 0, -4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restore_neg4", int'(bus.special), 8);
        pulseReset("rst_poison");

        // Poison ticks
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("poison_on", int'(bus.poisoned), 1);
        checkOutput("poison_h0", int'(bus.health), 175);
        tick(1'b0);
        checkOutput("poison_h1", int'(bus.health), 170);
        checkOutput("poison_sp1", int'(bus.special), 10);
        tick(1'b0);
        checkOutput("poison_h2", int'(bus.health), 165);
        checkOutput("poison_p2", int'(bus.poisoned), 1);
        tick(1'b0);
        checkOutput("poison_h3", int'(bus.health), 160);
        checkOutput("poison_p3", int'(bus.poisoned), 0);
        tick(1'b0);
        checkOutput("poison_h4", int'(bus.health), 160);
        checkOutput("poison_sp4", int'(bus.special), 10);
        pulseReset("rst_ko");

        // KO and revive
        for (int i = 0; i < 5; i++) hitOnce(31);
        applyStimulus(1'b1, 10, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ko_pre_h", int'(bus.health), 10);
        checkOutput("ko_pre_sp", int'(bus.special), 7);
        hitOnce(31);
        checkOutput("ko_h", int'(bus.health), 0);
        checkOutput("ko_flag", int'(bus.ko), 1);
        hitOnce(-20);
        checkOutput("ko_heal_ign", int'(bus.health), 0);
        tick(1'b1);
        checkOutput("ko_tick_sp", int'(bus.special), 7);
        checkOutput("ko_poison_ign", int'(bus.poisoned), 0);
        applyStimulus(1'b1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ko_reject0", int'(bus.reject), 0);
        checkOutput("ko_spend_ign", int'(bus.special), 7);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("revive_h", int'(bus.health), 87);
        checkOutput("revive_sp", int'(bus.special), 0);
        checkOutput("revive_ko", int'(bus.ko), 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("revive_alive_ign", int'(bus.health), 87);
        pulseReset("rst_sim");

        // Simultaneous events
        for (int i = 0; i < 5; i++) hitOnce(31);
        hitOnce(12);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("sim_pre_h", int'(bus.health), 8);
        applyStimulus(1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sim_h", int'(bus.health), 0);
        checkOutput("sim_ko", int'(bus.ko), 1);
        checkOutput("sim_pois", int'(bus.poisoned), 0);
        pulseReset("rst_reload");

        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, -10, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("net_clamp", int'(bus.health), 175);
        tick(1'b1);
        checkOutput("reload_h", int'(bus.health), 170);
        tick(1'b0);
        tick(1'b0);
        checkOutput("reload_h2", int'(bus.health), 160);
        checkOutput("reload_p2", int'(bus.poisoned), 1);
        tick(1'b0);
        checkOutput("reload_h3", int'(bus.health), 155);
        checkOutput("reload_p3", int'(bus.poisoned), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
